mc_control_fsm: RTL and testbench

Main control state machine for the RV32I multi-cycle, unpipelined core. It sequences the shared datapath (PC, IR, A/B operand registers, ALUOut, memory data register, single ALU, unified memory) one micro-step per clock. It decodes the opcode held in the instruction register and drives the mux selects, ALU operation class and write strobes. It stalls on a memory ready handshake and counts retired instructions.

---
 rtl/mc_control_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mc_control_fsm
// Description : Main control FSM for the RV32I multi-cycle core. Sequences the
//               shared datapath one micro-step per clock, decodes the IR
//               opcode, stalls on the memory ready handshake and counts
//               retired instructions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mc_control_fsm (
   input  logic        clk,
   input  logic        rst,          // asynchronous, active-low
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        mem_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  result_src,
   output logic        illegal,
   output logic [3:0]  state,
   output logic [31:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_JALR     = 4'd11,
      S_JALRJ    = 4'd12,
      S_LUI      = 4'd13,
      S_AUIPC    = 4'd14,
      S_BAD      = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t      state_q, state_d;
   logic [31:0] instret_q, instret_d;
   logic        decode_illegal;
   logic        retire;

   // State and retired-instruction counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Next-state logic, opcode dispatch and retirement detection
   always_comb begin
      state_d        = state_q;
      decode_illegal = 1'b0;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default: begin
                  state_d        = S_FETCH;
                  decode_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_BEQ:      state_d = S_FETCH;
         S_JALR:     state_d = S_JALRJ;
         S_JALRJ:    state_d = S_ALUWB;
         S_LUI:      state_d = S_ALUWB;
         S_AUIPC:    state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase

      // An instruction retires when it returns to FETCH from beyond DECODE;
      // illegal opcodes bounce straight from DECODE and are not counted.
      retire    = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_DECODE);
      instret_d = instret_q + {31'd0, retire};
   end

   // Moore output decode; strobes are gated off while reset is held
   always_comb begin
      logic pc_update;
      logic branch;
      logic ir_write_raw;
      logic mem_write_raw;
      logic reg_write_raw;

      mem_req       = 1'b0;
      adr_src       = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      result_src    = 2'b00;
      pc_update     = 1'b0;
      branch        = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req      = 1'b1;
            alu_src_b    = 2'b10;
            result_src   = 2'b10;
            ir_write_raw = mem_ready;
            pc_update    = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR, S_EXECUTEI, S_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = (state_q == S_EXECUTEI) ? 2'b10 : 2'b00;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req       = 1'b1;
            adr_src       = 1'b1;
            mem_write_raw = mem_ready;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_ALUWB:    reg_write_raw = 1'b1;
         S_JAL, S_JALRJ: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
         end
         S_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         default: ;
      endcase

      ir_write  = rst & ir_write_raw;
      pc_write  = rst & (pc_update | (branch & zero));
      mem_write = rst & mem_write_raw;
      reg_write = rst & reg_write_raw;
      illegal   = rst & (state_q == S_DECODE) & decode_illegal;
   end

   assign state   = state_q;
   assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mc_control_fsm
// Description : Self-checking bench for mc_control_fsm: vector table of whole
//               instructions, hand sequences for stalls/reset/wrap, and a
//               randomized run against an instruction-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, adr_src, ir_write, pc_write, mem_write, reg_write;
   logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] instret;

   mc_control_fsm dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
      .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
      .illegal(illegal), .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: current state plus the remaining micro-steps of the
   // instruction in flight, and the expected retired count
   int          ms;
   int          q[$];
   logic [31:0] m_instret;

   // last sampled DUT values
   logic [3:0]  s_state;
   logic        s_pcw, s_rw, s_ill, s_mw;

   typedef struct {
      logic [6:0]  op;
      logic        z;
      int          cyc;
      logic [23:0] path;
      int          pcw;
      int          rw;
      int          ill;
      int          dret;
      string       name;
   } vec_t;
   vec_t tbl[11];

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                          JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic is_valid(input logic [6:0] op);
      return op inside {LW, SW, RT, IT, BQ, JL, JR, LU, AU};
   endfunction

   // micro-steps following FETCH for each instruction class
   task automatic set_path(input logic [6:0] op);
      case (op)
         LW:      q = {1, 2, 3, 4};
         SW:      q = {1, 2, 5};
         RT:      q = {1, 6, 7};
         IT:      q = {1, 8, 7};
         BQ:      q = {1, 10};
         JL:      q = {1, 9, 7};
         JR:      q = {1, 11, 12, 7};
         LU:      q = {1, 13, 7};
         AU:      q = {1, 14, 7};
         default: q = {1};
      endcase
   endtask

   // expected {mem_req,adr_src,ir_write,pc_write,mem_write,reg_write,
   //           src_a,src_b,alu_op,result_src,illegal} for a state
   function automatic logic [14:0] exp_out(input int s, input logic rdy,
                                           input logic z, input logic [6:0] op);
      logic [7:0] sel;
      logic mreq, adr, irw, pcw, mw, rw, ill;
      sel = 8'h00; mreq = 0; adr = 0; irw = 0; pcw = 0; mw = 0; rw = 0; ill = 0;
      case (s)
         0:       begin sel = 8'b00_10_00_10; mreq = 1; irw = rdy; pcw = rdy; end
         1:       begin sel = 8'b01_01_00_00; ill = !is_valid(op); end
         2, 11:   sel = 8'b10_01_00_00;
         3:       begin mreq = 1; adr = 1; end
         4:       begin sel = 8'b00_00_00_01; rw = 1; end
         5:       begin mreq = 1; adr = 1; mw = rdy; end
         6:       sel = 8'b10_00_10_00;
         7:       rw = 1;
         8:       sel = 8'b10_01_10_00;
         9, 12:   begin sel = 8'b01_10_00_00; pcw = 1; end
         10:      begin sel = 8'b10_00_01_00; pcw = z; end
         13:      sel = 8'b11_01_00_00;
         14:      sel = 8'b01_01_00_00;
         default: ;
      endcase
      return {mreq, adr, irw, pcw, mw, rw, sel, ill};
   endfunction

   task automatic model_step();
      if (ms == 0) begin
         if (mem_ready) begin
            set_path(opcode);
            ms = q.pop_front();
         end
      end else if ((ms == 3 || ms == 5) && !mem_ready) begin
         // stalled on memory
      end else if (q.size() > 0) begin
         ms = q.pop_front();
      end else begin
         if (ms != 1) m_instret++;
         ms = 0;
      end
   endtask

   // one clock: drive at negedge, sample, advance model, step to next negedge
   task automatic cycle(input logic [6:0] op, input logic z, input logic rdy, input string tag);
      opcode = op; zero = z; mem_ready = rdy;
      #1;
      s_state = state; s_pcw = pc_write; s_rw = reg_write; s_ill = illegal; s_mw = mem_write;
      check({tag, "_state"}, {28'd0, state}, ms);
      check({tag, "_outs"}, {17'd0, mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
                              alu_src_a, alu_src_b, alu_op, result_src, illegal},
            {17'd0, exp_out(ms, rdy, z, op)});
      check({tag, "_instret"}, instret, m_instret);
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      ms = 0; q.delete(); m_instret = 32'd0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pcw_n, rw_n, ill_n, mw_n, cyc_n;
      logic [31:0] ret0;
      logic [3:0]  exp_s;

      tbl[0]  = '{LW, 1'b0, 5, 24'h012340, 1, 1, 0, 1, "lw"};
      tbl[1]  = '{SW, 1'b0, 4, 24'h012500, 1, 0, 0, 1, "sw"};
      tbl[2]  = '{RT, 1'b0, 4, 24'h016700, 1, 1, 0, 1, "rtype"};
      tbl[3]  = '{IT, 1'b1, 4, 24'h018700, 1, 1, 0, 1, "itype"};
      tbl[4]  = '{BQ, 1'b1, 3, 24'h01A000, 2, 0, 0, 1, "beq_taken"};
      tbl[5]  = '{BQ, 1'b0, 3, 24'h01A000, 1, 0, 0, 1, "beq_not"};
      tbl[6]  = '{JL, 1'b0, 4, 24'h019700, 2, 1, 0, 1, "jal"};
      tbl[7]  = '{JR, 1'b0, 5, 24'h01BC70, 2, 1, 0, 1, "jalr"};
      tbl[8]  = '{LU, 1'b0, 4, 24'h01D700, 1, 1, 0, 1, "lui"};
      tbl[9]  = '{AU, 1'b0, 4, 24'h01E700, 1, 1, 0, 1, "auipc"};
      tbl[10] = '{7'b1111111, 1'b0, 2, 24'h010000, 1, 0, 1, 0, "illegal"};

      // power-on reset with mem_ready high: strobes must stay gated
      rst = 1'b0; opcode = LW; zero = 1'b1; mem_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("por_state", {28'd0, state}, 32'd0);
      check("por_instret", instret, 32'd0);
      check("por_strobes", {27'd0, ir_write, pc_write, mem_write, reg_write, illegal}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // table-driven whole instructions with memory always ready
      foreach (tbl[i]) begin
         ret0 = instret; pcw_n = 0; rw_n = 0; ill_n = 0;
         for (int k = 0; k < tbl[i].cyc; k++) begin
            cycle(tbl[i].op, tbl[i].z, 1'b1, tbl[i].name);
            exp_s = tbl[i].path[23 - 4*k -: 4];
            check({tbl[i].name, "_path"}, {28'd0, s_state}, {28'd0, exp_s});
            pcw_n += int'(s_pcw); rw_n += int'(s_rw); ill_n += int'(s_ill);
         end
         check({tbl[i].name, "_end_fetch"}, {28'd0, state}, 32'd0);
         check({tbl[i].name, "_pcw_cnt"}, pcw_n, tbl[i].pcw);
         check({tbl[i].name, "_rw_cnt"}, rw_n, tbl[i].rw);
         check({tbl[i].name, "_ill_cnt"}, ill_n, tbl[i].ill);
         check({tbl[i].name, "_retired"}, instret - ret0, tbl[i].dret);
      end

      // store with three stall cycles in MEMWRITE
      cyc_n = 0; mw_n = 0; ret0 = instret;
      repeat (3) begin cycle(SW, 1'b0, 1'b1, "sw_stall"); cyc_n++; mw_n += int'(s_mw); end
      repeat (3) begin
         cycle(SW, 1'b0, 1'b0, "sw_stall");
         cyc_n++; mw_n += int'(s_mw);
         check("sw_stall_hold", {28'd0, s_state}, 32'd5);
      end
      cycle(SW, 1'b0, 1'b1, "sw_stall"); cyc_n++; mw_n += int'(s_mw);
      check("sw_stall_cycles", cyc_n, 7);
      check("sw_stall_mw_cnt", mw_n, 1);
      check("sw_stall_fetch", {28'd0, state}, 32'd0);
      check("sw_stall_retired", instret - ret0, 32'd1);

      // asynchronous reset in the middle of MEMREAD
      repeat (3) cycle(LW, 1'b0, 1'b1, "rst_mid");
      mem_ready = 1'b0;
      #1;
      check("rst_mid_in_memread", {28'd0, state}, 32'd3);
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_state", {28'd0, state}, 32'd0);
      check("rst_mid_instret", instret, 32'd0);
      mem_ready = 1'b1;
      #1;
      check("rst_mid_strobes", {27'd0, ir_write, pc_write, mem_write, reg_write, illegal}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_state", {28'd0, state}, 32'd0);
      check("rst_hold_strobes", {27'd0, ir_write, pc_write, mem_write, reg_write, illegal}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      // counter wrap: preset to all ones, retire one R-type
      mem_ready = 1'b0;
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      check("wrap_preset", instret, 32'hFFFF_FFFF);
      m_instret = 32'hFFFF_FFFF;
      @(negedge clk);
      repeat (4) cycle(RT, 1'b0, 1'b1, "wrap");
      check("wrap_result", instret, 32'd0);

      // randomized run against the instruction-level model
      for (int n = 0; n < 3000; n++) begin
         logic [6:0] op;
         logic [6:0] valid_ops [9];
         valid_ops = '{LW, SW, RT, IT, BQ, JL, JR, LU, AU};
         op = opcode;
         if (ms == 0) begin
            if ($urandom_range(0, 11) < 9) op = valid_ops[$urandom_range(0, 8)];
            else op = 7'($urandom);
         end
         cycle(op, 1'($urandom), ($urandom_range(0, 9) < 7), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
